// File: rtl/edf_ar_scheduler.sv
// Earliest-deadline-first arbiter merging NUM_PORTS AXI read-address channels
// onto one downstream AR channel; each port carries a relative-deadline counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | pick the eligible port with the smallest deadline, accept it
// ST_ISSUE | hold captured AR on m00_axi_* until m00_axi_arready
module edf_ar_scheduler #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = 40,
  parameter int ID_WIDTH     = 16,
  parameter int PERIOD_WIDTH = 16,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                               m00_axi_aclk,
  input  logic                               m00_axi_areset,
  input  logic [NUM_PORTS-1:0]               s_arvalid,
  output logic [NUM_PORTS-1:0]               s_arready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    s_araddr,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]      s_arid,
  input  logic [NUM_PORTS*8-1:0]             s_arlen,
  input  logic [NUM_PORTS*PERIOD_WIDTH-1:0]  period,
  output logic                               m00_axi_arvalid,
  input  logic                               m00_axi_arready,
  output logic [ADDR_WIDTH-1:0]              m00_axi_araddr,
  output logic [ID_WIDTH-1:0]                m00_axi_arid,
  output logic [7:0]                         m00_axi_arlen,
  output logic [GW-1:0]                      grant_port,
  output logic [15:0]                        miss_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t state_q, state_d;

  logic [NUM_PORTS-1:0][PERIOD_WIDTH-1:0] per_w;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_w;
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]     id_w;
  logic [NUM_PORTS-1:0][7:0]              len_w;

  logic [NUM_PORTS-1:0][PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
  logic [ID_WIDTH-1:0]                    id_q, id_d;
  logic [7:0]                             len_q, len_d;
  logic [GW-1:0]                          grant_q, grant_d;
  logic [15:0]                            miss_count_q, miss_count_d;

  logic [NUM_PORTS-1:0]    eligible;
  logic [NUM_PORTS-1:0]    at_zero;
  logic                    sel_found;
  logic [GW-1:0]           sel_idx;
  logic [PERIOD_WIDTH-1:0] sel_cnt;
  logic                    accept;
  logic                    issue_done;
  logic                    miss_evt;

  assign per_w  = period;
  assign addr_w = s_araddr;
  assign id_w   = s_arid;
  assign len_w  = s_arlen;

  always_comb begin
    eligible = '0;
    at_zero  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = s_arvalid[i] && (per_w[i] != '0);
      at_zero[i]  = (cnt_q[i] == '0);
    end
  end

  // Strict less-than while scanning upward gives the lowest index on ties.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_cnt   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (eligible[i] && (!sel_found || (cnt_q[i] < sel_cnt))) begin
        sel_found = 1'b1;
        sel_idx   = GW'(i);
        sel_cnt   = cnt_q[i];
      end
    end
  end

  assign accept     = (state_q == ST_IDLE) && sel_found && !m00_axi_areset;
  assign issue_done = (state_q == ST_ISSUE) && m00_axi_arready;

  // State register
  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)          state_d = ST_ISSUE;
      ST_ISSUE: if (m00_axi_arready) state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_arready = '0;
    if (accept) begin
      s_arready[sel_idx] = 1'b1;
    end
    m00_axi_arvalid = (state_q == ST_ISSUE);
    m00_axi_araddr  = addr_q;
    m00_axi_arid    = id_q;
    m00_axi_arlen   = len_q;
    grant_port      = grant_q;
    miss_count      = miss_count_q;
  end

  // Period is only sampled when a counter reloads, so a mid-count change of
  // period takes effect at that port's next grant, not on the running count.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = at_zero[i] ? '0 : cnt_q[i] - PERIOD_WIDTH'(1);
      if (issue_done && (grant_q == GW'(i))) begin
        cnt_d[i] = per_w[i];
      end
    end
  end

  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    grant_d = grant_q;
    if (accept) begin
      addr_d  = addr_w[sel_idx];
      id_d    = id_w[sel_idx];
      len_d   = len_w[sel_idx];
      grant_d = sel_idx;
    end
  end

  assign miss_evt = |(eligible & at_zero & ~s_arready);

  always_comb begin
    miss_count_d = miss_count_q;
    if (miss_evt && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      cnt_q        <= per_w;
      addr_q       <= '0;
      id_q         <= '0;
      len_q        <= '0;
      grant_q      <= '0;
      miss_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      len_q        <= len_d;
      grant_q      <= grant_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_edf_ar_scheduler.sv
// Bench for edf_ar_scheduler: selection vector table, scoreboarded grant order,
// and hand sequences for backpressure, disable, miss counting and reset.
module tb_edf_ar_scheduler;
  localparam int NP = 4;
  localparam int AW = 40;
  localparam int IW = 16;
  localparam int PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NP-1:0]    s_arvalid, s_arready;
  logic [NP*AW-1:0] s_araddr;
  logic [NP*IW-1:0] s_arid;
  logic [NP*8-1:0]  s_arlen;
  logic [NP*PW-1:0] period;
  logic             m_arvalid, m_arready;
  logic [AW-1:0]    m_araddr;
  logic [IW-1:0]    m_arid;
  logic [7:0]       m_arlen;
  logic [1:0]       grant_port;
  logic [15:0]      miss_count;

  edf_ar_scheduler #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .PERIOD_WIDTH(PW)) dut (
    .m00_axi_aclk   (clk),
    .m00_axi_areset (rst),
    .s_arvalid      (s_arvalid),
    .s_arready      (s_arready),
    .s_araddr       (s_araddr),
    .s_arid         (s_arid),
    .s_arlen        (s_arlen),
    .period         (period),
    .m00_axi_arvalid(m_arvalid),
    .m00_axi_arready(m_arready),
    .m00_axi_araddr (m_araddr),
    .m00_axi_arid   (m_arid),
    .m00_axi_arlen  (m_arlen),
    .grant_port     (grant_port),
    .miss_count     (miss_count)
  );

  typedef struct {
    logic [1:0]    port;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
  } exp_t;

  typedef struct {
    logic [NP*PW-1:0] per;
    logic [NP-1:0]    valid;
    logic [NP-1:0]    exp_rdy;
    logic [1:0]       exp_gnt;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   auto_drop;

  function automatic logic [NP*PW-1:0] mkp(int p0, int p1, int p2, int p3);
    return {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
  endfunction

  function automatic logic [AW-1:0] addr_of(int p, int salt);
    return {8'(160 + p), 24'(salt), 8'(p)};
  endfunction

  function automatic logic [IW-1:0] id_of(int p, int salt);
    return {8'(p + 1), 8'(salt)};
  endfunction

  function automatic logic [7:0] len_of(int p, int salt);
    return 8'(p * 16 + salt);
  endfunction

  function automatic exp_t mk_exp(int p, int salt);
    exp_t e;
    e.port = 2'(p);
    e.addr = addr_of(p, salt);
    e.id   = id_of(p, salt);
    e.len  = len_of(p, salt);
    return e;
  endfunction

  task automatic load_data(int salt);
    for (int p = 0; p < NP; p++) begin
      s_araddr[p*AW +: AW] = addr_of(p, salt);
      s_arid[p*IW +: IW]   = id_of(p, salt);
      s_arlen[p*8 +: 8]    = len_of(p, salt);
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, let the rising edge happen, then
  // retire requests that were accepted on that edge.
  task automatic tick();
    logic [NP-1:0] acc;
    exp_t e;
    @(negedge clk);
    acc = s_arvalid & s_arready;
    if (m_arvalid && m_arready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: issue of port %0d with nothing expected", grant_port);
      end else begin
        e = sbq.pop_front();
        chk("sb_grant", grant_port, e.port);
        chk("sb_addr", m_araddr, e.addr);
        chk("sb_id", m_arid, e.id);
        chk("sb_len", m_arlen, e.len);
      end
    end
    @(posedge clk);
    #1;
    if (auto_drop) s_arvalid = s_arvalid & ~acc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(int budget, string nm);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL %s: timeout, got %0d pending grants, expected 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    int   cnt, em;
    int   rp[4];
    rp = '{12, 34, 56, 78};

    vecs[0] = '{mkp(40, 10, 30, 20), 4'b1111, 4'b0010, 2'd1};
    vecs[1] = '{mkp(40, 10, 30, 20), 4'b1001, 4'b1000, 2'd3};
    vecs[2] = '{mkp(8, 8, 8, 8),     4'b0101, 4'b0001, 2'd0};
    vecs[3] = '{mkp(0, 3, 9, 9),     4'b1111, 4'b0010, 2'd1};
    vecs[4] = '{mkp(7, 7, 0, 0),     4'b1100, 4'b0000, 2'd0};
    vecs[5] = '{mkp(9, 9, 9, 9),     4'b0000, 4'b0000, 2'd0};
    vecs[6] = '{mkp(6, 6, 2, 6),     4'b1100, 4'b0100, 2'd2};
    vecs[7] = '{mkp(1, 65535, 65535, 3), 4'b1110, 4'b1000, 2'd3};

    rst = 1'b1; s_arvalid = '0; m_arready = 1'b0; auto_drop = 1'b0;
    period = mkp(1, 1, 1, 1);
    load_data(0);
    tick();
    tick();
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_grant", grant_port, 0);
    chk("rst_addr", m_araddr, 0);
    chk("rst_len", m_arlen, 0);
    rst = 1'b0;

    // selection table, each from a fresh reset so counters equal periods
    for (int v = 0; v < 8; v++) begin
      period = vecs[v].per; s_arvalid = '0; m_arready = 1'b0;
      do_reset();
      s_arvalid = vecs[v].valid;
      #1;
      chk($sformatf("vec%0d_arready", v), s_arready, vecs[v].exp_rdy);
      tick();
      chk($sformatf("vec%0d_arvalid", v), m_arvalid, |vecs[v].exp_rdy);
      if (|vecs[v].exp_rdy) begin
        chk($sformatf("vec%0d_grant", v), grant_port, vecs[v].exp_gnt);
        chk($sformatf("vec%0d_addr", v), m_araddr, addr_of(int'(vecs[v].exp_gnt), 0));
      end
    end

    // EDF order
    auto_drop = 1'b1; m_arready = 1'b0;
    period = mkp(40, 10, 30, 20); load_data(1); s_arvalid = 4'b1111;
    do_reset();
    m_arready = 1'b1;
    sbq.push_back(mk_exp(1, 1)); sbq.push_back(mk_exp(3, 1));
    sbq.push_back(mk_exp(2, 1)); sbq.push_back(mk_exp(0, 1));
    wait_drain(40, "edf_order");
    chk("edf_miss", miss_count, 0);

    // tie-break
    m_arready = 1'b0; period = mkp(8, 8, 8, 8); load_data(2); s_arvalid = 4'b0101;
    do_reset();
    m_arready = 1'b1;
    sbq.push_back(mk_exp(0, 2)); sbq.push_back(mk_exp(2, 2));
    wait_drain(20, "tie_order");

    // backpressure, with requester dropping valid and changing data mid-ISSUE
    m_arready = 1'b0; s_arvalid = '0; period = mkp(20, 20, 20, 20); load_data(3);
    do_reset();
    s_arvalid = 4'b0100;
    #1;
    chk("bp_sel", s_arready, 4'b0100);
    chk("bp_pre_arvalid", m_arvalid, 0);
    tick();
    eb = mk_exp(2, 3);
    chk("bp_latency", m_arvalid, 1);
    chk("bp_grant", grant_port, 2);
    load_data(9);
    s_arvalid = s_arvalid | 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_no_arready", s_arready, 0);
      tick();
      chk("bp_hold_valid", m_arvalid, 1);
      chk("bp_hold_addr", m_araddr, eb.addr);
      chk("bp_hold_id", m_arid, eb.id);
      chk("bp_hold_len", m_arlen, eb.len);
    end
    sbq.push_back(eb);
    m_arready = 1'b1;
    tick();
    chk("bp_idle_after", m_arvalid, 0);
    #1;
    chk("bp_next_sel", s_arready, 4'b0001);
    m_arready = 1'b0; s_arvalid = '0;

    // disabled port
    period = mkp(5, 5, 5, 0);
    do_reset();
    s_arvalid = 4'b1000; m_arready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("dis_arready", s_arready, 0);
      tick();
    end
    chk("dis_arvalid", m_arvalid, 0);
    chk("dis_miss", miss_count, 0);

    // miss counting: request held valid while stuck in ISSUE
    auto_drop = 1'b0; m_arready = 1'b0; s_arvalid = '0; period = mkp(4, 0, 0, 0);
    do_reset();
    s_arvalid = 4'b0001;
    cnt = 4; em = 0;
    for (int k = 0; k < 14; k++) begin
      #1;
      chk($sformatf("miss_c%0d", k), miss_count, em);
      if (cnt == 0 && k != 0 && em != 65535) em++;
      cnt = (cnt != 0) ? cnt - 1 : 0;
      tick();
    end
    chk("miss_final", miss_count, 10);

    force dut.miss_count_q = 16'hFFFE;
    #1;
    chk("sat_from_fffe", dut.miss_count_d, 16'hFFFF);
    force dut.miss_count_q = 16'hFFFF;
    #1;
    chk("sat_hold", dut.miss_count_d, 16'hFFFF);
    release dut.miss_count_q;

    // reset while ISSUE is pending
    chk("rmi_pre_arvalid", m_arvalid, 1);
    period = mkp(rp[0], rp[1], rp[2], rp[3]);
    do_reset();
    chk("rmi_arvalid", m_arvalid, 0);
    chk("rmi_miss", miss_count, 0);
    chk("rmi_grant", grant_port, 0);
    chk("rmi_addr", m_araddr, 0);
    chk("rmi_id", m_arid, 0);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("rmi_cnt%0d", i), dut.cnt_q[i], rp[i]);
    end

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
